// File: rtl/siren_detector.sv
// Siren detector: measures audio_in rising-edge periods, locks tone 1/2 after HOLD matching periods
// and flags a siren after ALT_COUNT tone changes. Define SIREN_DET_GLITCH_EN for a 4-cycle input filter.
module siren_detector #(
   parameter int unsigned P1_MIN    = 128250,
   parameter int unsigned P1_MAX    = 141750,
   parameter int unsigned P2_MIN    = 73285,
   parameter int unsigned P2_MAX    = 80999,
   parameter int unsigned HOLD      = 3,
   parameter int unsigned ALT_COUNT = 4,
   parameter int unsigned TIMEOUT   = 300000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        audio_in,
   output logic [1:0]  tone,
   output logic        siren,
   output logic [23:0] period,
   output logic        period_valid
);

   typedef enum logic [1:0] {StIdle = 2'b00, StTone1 = 2'b01, StTone2 = 2'b10} state_e;
   typedef enum logic [1:0] {ClsX = 2'b00, Cls1 = 2'b01, Cls2 = 2'b10} cls_e;

   localparam logic [23:0] CntMax   = 24'hFFFFFF;
   localparam logic [23:0] P1Lo     = 24'(P1_MIN);
   localparam logic [23:0] P1Hi     = 24'(P1_MAX);
   localparam logic [23:0] P2Lo     = 24'(P2_MIN);
   localparam logic [23:0] P2Hi     = 24'(P2_MAX);
   localparam logic [23:0] Timeout  = 24'(TIMEOUT);
   localparam logic [3:0]  Hold     = 4'(HOLD);
   localparam logic [3:0]  AltCount = 4'(ALT_COUNT);

   logic        sync1_q, sync2_q;
   logic        lvl, lvl_prev_q, rise;
   logic [23:0] cnt_q, cnt_d;
   logic        have_q, have_d;
   logic [3:0]  run_q, run_d;
   cls_e        run_cls_q, run_cls_d;
   cls_e        cls;
   state_e      state_q, state_d;
   logic [3:0]  alt_q, alt_d;
   logic        siren_q, siren_d;
   logic [23:0] period_q, period_d;
   logic        pv_q, pv_d;
   logic        tmo, meas;

`ifdef SIREN_DET_GLITCH_EN
   logic       filt_q;
   logic [1:0] stab_q;

   // Accept a new level once sync2 has held it for three cycles and sync1 confirms a fourth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b0;
         stab_q <= 2'd0;
      end else if (sync2_q == filt_q) begin
         stab_q <= 2'd0;
      end else if (stab_q == 2'd2) begin
         if (sync1_q == sync2_q) begin
            filt_q <= sync2_q;
            stab_q <= 2'd0;
         end
      end else begin
         stab_q <= stab_q + 2'd1;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync2_q;
`endif

   assign rise = lvl & ~lvl_prev_q;

   always_comb begin
      tmo = (cnt_q == Timeout);
      // Timeout wins over a coincident edge; that edge becomes the first edge of a new train.
      meas = rise & have_q & ~tmo;
      have_d = rise | (have_q & ~tmo);

      if (rise) begin
         cnt_d = 24'd1;
      end else if (cnt_q == CntMax) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 24'd1;
      end

      if (cnt_q >= P1Lo && cnt_q <= P1Hi) begin
         cls = Cls1;
      end else if (cnt_q >= P2Lo && cnt_q <= P2Hi) begin
         cls = Cls2;
      end else begin
         cls = ClsX;
      end

      run_d     = run_q;
      run_cls_d = run_cls_q;
      state_d   = state_q;
      alt_d     = alt_q;
      period_d  = meas ? cnt_q : period_q;
      pv_d      = meas;

      if (tmo) begin
         state_d   = StIdle;
         alt_d     = 4'd0;
         run_d     = 4'd0;
         run_cls_d = ClsX;
      end else if (meas) begin
         if (cls == ClsX) begin
            run_d     = 4'd0;
            run_cls_d = ClsX;
         end else if (cls == run_cls_q) begin
            run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
         end else begin
            run_d     = 4'd1;
            run_cls_d = cls;
         end

         if (cls != ClsX && run_d == Hold && state_q != state_e'(cls)) begin
            if (state_q != StIdle && alt_q != 4'hF) begin
               alt_d = alt_q + 4'd1;
            end
            state_d = state_e'(cls);
         end
      end

      siren_d = (alt_d >= AltCount);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         lvl_prev_q <= 1'b0;
         cnt_q      <= 24'd0;
         have_q     <= 1'b0;
         run_q      <= 4'd0;
         run_cls_q  <= ClsX;
         state_q    <= StIdle;
         alt_q      <= 4'd0;
         siren_q    <= 1'b0;
         period_q   <= 24'd0;
         pv_q       <= 1'b0;
      end else begin
         sync1_q    <= audio_in;
         sync2_q    <= sync1_q;
         lvl_prev_q <= lvl;
         cnt_q      <= cnt_d;
         have_q     <= have_d;
         run_q      <= run_d;
         run_cls_q  <= run_cls_d;
         state_q    <= state_d;
         alt_q      <= alt_d;
         siren_q    <= siren_d;
         period_q   <= period_d;
         pv_q       <= pv_d;
      end
   end

   assign tone         = state_q;
   assign siren        = siren_q;
   assign period       = period_q;
   assign period_valid = pv_q;

endmodule
